// File: rtl/libiu_pkg.sv
// libiu: shared integer-unit types and default parameters for the regfile write path.
package libiu;
    localparam int REGF_AW = 10;
    localparam int DBG_DEPTH = 4;
    localparam int STARVE_LIMIT_DEF = 16;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic [REGF_AW-1:0] addr;
        logic [31:0]        data;
        logic               we;
    } regf_wr_type;

    localparam regf_wr_type REGF_WR_IDLE = '0;

    function automatic regf_wr_type regf_wr(input logic [REGF_AW-1:0] addr, input logic [31:0] data);
        return regf_wr_type'{addr: addr, data: data, we: 1'b1};
    endfunction
endpackage

// File: rtl/regfile_wr_fifo.sv
// regfile_wr_fifo: circular debug-write queue, one push and up to two pops per cycle.
// Exposes head and head+1 so the scheduler can fill both write phases at once.
module regfile_wr_fifo
    import libiu::*;
#(
    parameter int DEPTH = DBG_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  regf_wr_type            din,
    input  logic [1:0]             pop,
    output regf_wr_type            head,
    output regf_wr_type            head1,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    regf_wr_type      mem [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;

    assign head  = mem[rd];
    assign head1 = mem[rd + PW'(1)];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push)
                wr <= wr + PW'(1);
            rd    <= rd + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset: only entries below count are ever issued.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr] <= din;
    end
endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: merges commit writes and queued debug writes onto the ph1/ph2
// regfile ports, commit first; raises iu_stall when debug writes starve.
module regfile_wr_sched
    import libiu::*;
#(
    parameter int AW           = REGF_AW,
    parameter int DEPTH        = DBG_DEPTH,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  iu_clk_type    gclk,
    input  logic          rstn,
    input  logic          c_ph1_we,
    input  logic [AW-1:0] c_ph1_addr,
    input  logic [31:0]   c_ph1_data,
    input  logic          c_ph2_we,
    input  logic [AW-1:0] c_ph2_addr,
    input  logic [31:0]   c_ph2_data,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_data,
    output logic [1:0]    dbg_ack,
    output logic          ph1_we,
    output logic [AW-1:0] ph1_addr,
    output logic [31:0]   ph1_data,
    output logic          ph2_we,
    output logic [AW-1:0] ph2_addr,
    output logic [31:0]   ph2_data,
    output logic          iu_stall
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam int NW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, STALL} state_t;

    logic          clk;
    regf_wr_type   head;
    regf_wr_type   head1;
    regf_wr_type   nx1;
    regf_wr_type   nx2;
    regf_wr_type   r1;
    regf_wr_type   r2;
    logic [NW-1:0] count;
    logic [1:0]    nfree;
    logic [1:0]    n;
    logic          push;
    logic [CW-1:0] starve;
    state_t        state;

    assign clk       = gclk.clk;
    assign dbg_ready = count < NW'(DEPTH);
    assign push      = dbg_valid && dbg_ready;

    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (regf_wr(dbg_addr, dbg_data)),
        .pop   (n),
        .head  (head),
        .head1 (head1),
        .count (count)
    );

    // Free phases take queue entries in order; ph2 lands after ph1 so order holds.
    always_comb begin
        nfree = {1'b0, !c_ph1_we} + {1'b0, !c_ph2_we};
        n     = (NW'(nfree) > count) ? count[1:0] : nfree;
        nx1   = c_ph1_we ? regf_wr(c_ph1_addr, c_ph1_data) : (n != 2'd0 ? head : REGF_WR_IDLE);
        nx2   = c_ph2_we ? regf_wr(c_ph2_addr, c_ph2_data)
              : c_ph1_we ? (n != 2'd0 ? head : REGF_WR_IDLE)
              : (n == 2'd2 ? head1 : REGF_WR_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1      <= REGF_WR_IDLE;
            r2      <= REGF_WR_IDLE;
            dbg_ack <= '0;
            starve  <= '0;
            state   <= RUN;
        end else begin
            r1      <= nx1;
            r2      <= nx2;
            dbg_ack <= n;
            starve  <= (count == '0 || n != 2'd0) ? '0
                     : (starve == CW'(STARVE_LIMIT) ? starve : starve + CW'(1));
            state   <= (state == RUN) ? (starve == CW'(STARVE_LIMIT) ? STALL : RUN)
                     : (count == '0 ? RUN : STALL);
        end
    end

    assign iu_stall = state == STALL;
    assign ph1_we   = r1.we;
    assign ph1_addr = r1.addr;
    assign ph1_data = r1.data;
    assign ph2_we   = r2.we;
    assign ph2_addr = r2.addr;
    assign ph2_data = r2.data;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed scenarios plus randomized traffic checked against
// a queue-based model of the write scheduler.
module tb_regfile_wr_sched;
    import libiu::*;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int LIM   = 16;

    logic          clk = 1'b0;
    iu_clk_type    gclk;
    logic          rstn;
    logic          c_ph1_we, c_ph2_we, dbg_valid, dbg_ready;
    logic [AW-1:0] c_ph1_addr, c_ph2_addr, dbg_addr, ph1_addr, ph2_addr;
    logic [31:0]   c_ph1_data, c_ph2_data, dbg_data, ph1_data, ph2_data;
    logic [1:0]    dbg_ack;
    logic          ph1_we, ph2_we, iu_stall;

    assign gclk.clk = clk;
    always #5 clk = ~clk;

    regfile_wr_sched #(.AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .gclk(gclk), .rstn(rstn),
        .c_ph1_we(c_ph1_we), .c_ph1_addr(c_ph1_addr), .c_ph1_data(c_ph1_data),
        .c_ph2_we(c_ph2_we), .c_ph2_addr(c_ph2_addr), .c_ph2_data(c_ph2_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .ph1_we(ph1_we), .ph1_addr(ph1_addr), .ph1_data(ph1_data),
        .ph2_we(ph2_we), .ph2_addr(ph2_addr), .ph2_data(ph2_data),
        .iu_stall(iu_stall)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } ent_t;

    ent_t        q[$];
    int          st;
    bit          stl;
    regf_wr_type x1, x2;
    int          xack;
    logic [31:0] rf [1024];
    int          vectors, errs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ph1_we", 64'(ph1_we), 64'(x1.we));
        chk("ph1_addr", 64'(ph1_addr), 64'(x1.addr));
        chk("ph1_data", 64'(ph1_data), 64'(x1.data));
        chk("ph2_we", 64'(ph2_we), 64'(x2.we));
        chk("ph2_addr", 64'(ph2_addr), 64'(x2.addr));
        chk("ph2_data", 64'(ph2_data), 64'(x2.data));
        chk("dbg_ack", 64'(dbg_ack), 64'(xack));
        chk("iu_stall", 64'(iu_stall), 64'(stl));
        chk("dbg_ready", 64'(dbg_ready), 64'(q.size() < DEPTH));
        if (ph1_we) rf[ph1_addr] = ph1_data;
        if (ph2_we) rf[ph2_addr] = ph2_data;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit w1, input int a1, input logic [31:0] d1,
                       input bit w2, input int a2, input logic [31:0] d2,
                       input bit v, input int da, input logic [31:0] dd);
        int   n, k, sz;
        ent_t iss[$];
        c_ph1_we = w1; c_ph1_addr = AW'(a1); c_ph1_data = d1;
        c_ph2_we = w2; c_ph2_addr = AW'(a2); c_ph2_data = d2;
        dbg_valid = v; dbg_addr = AW'(da); dbg_data = dd;
        sz = q.size();
        n  = int'(!w1) + int'(!w2);
        if (n > sz) n = sz;
        for (int i = 0; i < n; i++) iss.push_back(q.pop_front());
        x1 = '0; x2 = '0; k = 0;
        if (w1) x1 = regf_wr_type'{addr: AW'(a1), data: d1, we: 1'b1};
        else if (k < n) begin x1 = regf_wr_type'{addr: iss[k].a, data: iss[k].d, we: 1'b1}; k++; end
        if (w2) x2 = regf_wr_type'{addr: AW'(a2), data: d2, we: 1'b1};
        else if (k < n) begin x2 = regf_wr_type'{addr: iss[k].a, data: iss[k].d, we: 1'b1}; k++; end
        if (v && sz < DEPTH) q.push_back('{AW'(da), dd});
        if (!stl && st == LIM) stl = 1;
        else if (stl && sz == 0) stl = 0;
        st   = (sz == 0 || n > 0) ? 0 : (st < LIM ? st + 1 : LIM);
        xack = n;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        q.delete(); st = 0; stl = 0; x1 = '0; x2 = '0; xack = 0;
        check_all();
        @(negedge clk) rstn = 1'b1;
    endtask

    initial begin
        int busy;
        vectors = 0; errs = 0; st = 0; stl = 0; xack = 0; x1 = '0; x2 = '0;
        for (int i = 0; i < 1024; i++) rf[i] = '0;
        rstn = 1'b0;
        c_ph1_we = 0; c_ph1_addr = '0; c_ph1_data = '0;
        c_ph2_we = 0; c_ph2_addr = '0; c_ph2_data = '0;
        dbg_valid = 0; dbg_addr = '0; dbg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rstn = 1'b1;

        // Two queued entries leave together on ph1/ph2 once commit goes idle.
        cyc(1, 1, 1, 1, 2, 2, 1, 5, 32'h11);
        cyc(1, 1, 1, 1, 2, 2, 1, 6, 32'h22);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pair_ph1_addr", 64'(ph1_addr), 64'd5);
        chk("pair_ph2_data", 64'(ph2_data), 64'h22);
        chk("pair_ack", 64'(dbg_ack), 64'd2);

        // Commit on ph1 only: debug entry takes ph2 in the same cycle.
        cyc(1, 3, 32'h33, 0, 0, 0, 1, 7, 32'h77);
        cyc(1, 3, 32'h33, 0, 0, 0, 0, 0, 0);
        chk("share_ph1", 64'(ph1_addr), 64'd3);
        chk("share_ph2", 64'(ph2_addr), 64'd7);
        chk("share_ack", 64'(dbg_ack), 64'd1);

        // Starvation: stall rises LIM+1 cycles after the push, falls once drained.
        cyc(1, 1, 1, 1, 2, 2, 1, 8, 32'h88);
        repeat (LIM) cyc(1, 1, 1, 1, 2, 2, 0, 0, 0);
        chk("stall_not_yet", 64'(iu_stall), 64'd0);
        cyc(1, 1, 1, 1, 2, 2, 0, 0, 0);
        chk("stall_rise", 64'(iu_stall), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_fall", 64'(iu_stall), 64'd0);

        // Commit and debug write to the same address: the debug value lands last.
        cyc(1, 1, 1, 1, 2, 2, 1, 9, 32'hBB);
        cyc(1, 9, 32'hAA, 1, 4, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("collide_rf9", 64'(rf[9]), 64'hBB);

        // Fill to DEPTH with commit blocked, then pop/push around full.
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 1, 1, 1, 2, 2, 1, 20 + i, 32'h100 + i);
        chk("full_ready", 64'(dbg_ready), 64'd0);
        repeat (LIM + 2) cyc(1, 1, 1, 1, 2, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 2, 1, 40, 32'h400);
        cyc(1, 1, 1, 1, 2, 2, 1, 41, 32'h410);
        chk("refill_ready", 64'(dbg_ready), 64'd0);
        cyc(0, 0, 0, 1, 2, 2, 0, 0, 0);
        chk("stall_held", 64'(iu_stall), 64'd1);

        // Reset with three entries queued and stall active.
        do_reset();
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with varying commit pressure.
        busy = 5;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) busy = $urandom_range(2, 10);
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc($urandom_range(0, 9) < busy, $urandom_range(0, 1023), $urandom,
                $urandom_range(0, 9) < busy, $urandom_range(0, 1023), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 1023), $urandom);
        end
        repeat (DEPTH + 2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
